cv_bus_master: RTL and testbench

- Z80-compatible bus cycle generator; the initiating end of the memory/I/O strobe interface consumed by the console address decoder.
- Converts single-beat commands from on-chip agents (ADAM loader, debug/DMA port) into T-state-accurate MREQ/IORQ/RD/WR/RFSH sequences.
- Drives the same a/d/strobe nets the CPU drives, so the decoder and memories cannot tell it apart from the Z80.
- One clk_i cycle = one T-state.

---
 rtl/cv_bus_pkg.sv | 33 +++
 rtl/cv_bus_master.sv | 235 +++++++++++++++++++++++
 tb/tb_cv_bus_master.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv_bus_pkg.sv
// Shared types for the Z80-style bus cycle generator: command encoding,
// bus state encoding and the fixed upper byte of refresh addresses.
package cv_bus_pkg;

    typedef enum logic [1:0] {
        CMD_MRD  = 2'b00,
        CMD_MWR  = 2'b01,
        CMD_IORD = 2'b10,
        CMD_IOWR = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TWA  = 3'd3,
        ST_TW   = 3'd4,
        ST_T3   = 3'd5,
        ST_R1   = 3'd6,
        ST_R2   = 3'd7
    } state_t;

    localparam logic [7:0] REFRESH_ADDR_HI = 8'h00;

    function automatic logic cmd_is_io(input cmd_t c);
        return (c == CMD_IORD) || (c == CMD_IOWR);
    endfunction

    function automatic logic cmd_is_write(input cmd_t c);
        return (c == CMD_MWR) || (c == CMD_IOWR);
    endfunction

endpackage

// File: rtl/cv_bus_master.sv
// Z80-compatible bus cycle generator: one command in, one T-state-accurate
// MREQ/IORQ/RD/WR cycle out. CV_BUS_RFSH_EN appends R1/R2 refresh to mem reads.
module cv_bus_master
    import cv_bus_pkg::*;
#(
    parameter int IO_AUTO_WAIT = 1,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic [1:0]  cmd_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [7:0]  rdata_o,
    output logic        busy_o,
    output logic [15:0] a_o,
    output logic [7:0]  d_o,
    output logic        d_oe_o,
    input  logic [7:0]  d_i,
    output logic        mreq_n_o,
    output logic        iorq_n_o,
    output logic        rd_n_o,
    output logic        wr_n_o,
    output logic        rfsh_n_o,
    input  logic        wait_n_i,
    output state_t      dbg_state_o
);

    // Handshake: req_i is accepted only while busy_o is low (IDLE); every
    // accepted request yields exactly one ack_o pulse (with err_o) unless a
    // reset intervenes, and req_i may be held high in that ack cycle.

    localparam logic [1:0] TWA_LAST      = 2'(IO_AUTO_WAIT - 1);
    localparam logic [7:0] TIMEOUT_CNT   = 8'(WAIT_TIMEOUT);
    localparam logic       HAS_AUTO_WAIT = (IO_AUTO_WAIT > 0);

    state_t      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic [15:0] a_q, a_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  twa_cnt_q, twa_cnt_d;
    logic        abort_q, abort_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic        is_io;
    logic        is_write;
    logic [7:0]  wait_cnt_inc;
    logic        timeout_hit;

`ifdef CV_BUS_RFSH_EN
    logic [6:0]  r_q, r_d;
`endif

    assign is_io        = cmd_is_io(cmd_q);
    assign is_write     = cmd_is_write(cmd_q);
    assign wait_cnt_inc = wait_cnt_q + 8'd1;
    assign timeout_hit  = !wait_n_i && (wait_cnt_inc == TIMEOUT_CNT);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_MRD;
            a_q        <= '0;
            dout_q     <= '0;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
            twa_cnt_q  <= '0;
            abort_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            a_q        <= a_d;
            dout_q     <= dout_d;
            rdata_q    <= rdata_d;
            wait_cnt_q <= wait_cnt_d;
            twa_cnt_q  <= twa_cnt_d;
            abort_q    <= abort_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

`ifdef CV_BUS_RFSH_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = ST_T1;
                end
            end
            ST_T1: state_d = ST_T2;
            ST_T2: begin
                if (is_io && HAS_AUTO_WAIT) begin
                    state_d = ST_TWA;
                end else if (!wait_n_i) begin
                    state_d = ST_TW;
                end else begin
                    state_d = ST_T3;
                end
            end
            ST_TWA: begin
                // Only the final auto-wait cycle looks at the wait input.
                if (twa_cnt_q == TWA_LAST) begin
                    state_d = wait_n_i ? ST_T3 : ST_TW;
                end
            end
            ST_TW: begin
                if (wait_n_i || timeout_hit) begin
                    state_d = ST_T3;
                end
            end
            ST_T3: begin
`ifdef CV_BUS_RFSH_EN
                state_d = (cmd_q == CMD_MRD) ? ST_R1 : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef CV_BUS_RFSH_EN
            ST_R1: state_d = ST_R2;
            ST_R2: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_d      = cmd_q;
        a_d        = a_q;
        dout_d     = dout_q;
        rdata_d    = rdata_q;
        wait_cnt_d = wait_cnt_q;
        twa_cnt_d  = twa_cnt_q;
        abort_d    = abort_q;
`ifdef CV_BUS_RFSH_EN
        r_d        = r_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    cmd_d      = cmd_t'(cmd_i);
                    a_d        = addr_i;
                    wait_cnt_d = '0;
                    twa_cnt_d  = '0;
                    abort_d    = 1'b0;
                    if (cmd_i[0]) begin
                        dout_d = wdata_i;
                    end
                end
            end
            ST_TWA: twa_cnt_d = twa_cnt_q + 2'd1;
            ST_TW: begin
                wait_cnt_d = wait_cnt_inc;
                if (timeout_hit) begin
                    abort_d = 1'b1;
                end
            end
            ST_T3: begin
                if (!is_write && !abort_q) begin
                    rdata_d = d_i;
                end
`ifdef CV_BUS_RFSH_EN
                if (state_d == ST_R1) begin
                    a_d = {REFRESH_ADDR_HI, 1'b0, r_q};
                end
`endif
            end
`ifdef CV_BUS_RFSH_EN
            ST_R2: r_d = r_q + 7'd1;
`endif
            default: ;
        endcase
        ack_d = ((state_q == ST_T3) && (state_d == ST_IDLE)) || (state_q == ST_R2);
        err_d = ack_d && abort_q;
    end

    always_comb begin
        mreq_n_o = 1'b1;
        iorq_n_o = 1'b1;
        rd_n_o   = 1'b1;
        wr_n_o   = 1'b1;
        rfsh_n_o = 1'b1;
        d_oe_o   = 1'b0;
        case (state_q)
            ST_T1: begin
                // I/O strobes wait for T2; memory strobes start in T1.
                mreq_n_o = is_io;
                rd_n_o   = is_io || is_write;
                d_oe_o   = is_write;
            end
            ST_T2, ST_TWA, ST_TW, ST_T3: begin
                mreq_n_o = is_io;
                iorq_n_o = !is_io;
                rd_n_o   = is_write;
                wr_n_o   = !is_write;
                d_oe_o   = is_write;
            end
`ifdef CV_BUS_RFSH_EN
            ST_R1: begin
                mreq_n_o = 1'b0;
                rfsh_n_o = 1'b0;
            end
            ST_R2: rfsh_n_o = 1'b0;
`endif
            default: ;
        endcase
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign a_o         = a_q;
    assign d_o         = dout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cv_bus_master.sv
// Self-checking bench for cv_bus_master: two instances (default timeout and
// a short timeout) share all inputs; a cycle-level schedule model predicts both.
module tb_cv_bus_master;
    import cv_bus_pkg::*;

    localparam int AW  = 1;
    localparam int TO0 = 255;
    localparam int TO1 = 3;
`ifdef CV_BUS_RFSH_EN
    localparam bit RF = 1'b1;
`else
    localparam bit RF = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic        oe;
        logic        mreq;
        logic        iorq;
        logic        rd;
        logic        wr;
        logic        rfsh;
        logic        busy;
        logic        ack;
        logic        err;
        logic [7:0]  rdata;
    } obs_t;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        int          ws;
        int          wl;
        int          lat0;
        bit          err0;
        int          lat1;
        bit          err1;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_i;
    logic [1:0]  cmd_i;
    logic [15:0] addr_i;
    logic [7:0]  wdata_i;
    logic [7:0]  d_i;
    logic        wait_n_i;

    logic        ack_w[2], err_w[2], busy_w[2], oe_w[2];
    logic        mreq_w[2], iorq_w[2], rd_w[2], wr_w[2], rfsh_w[2];
    logic [7:0]  rdata_w[2], d_w[2];
    logic [15:0] a_w[2];
    state_t      st_w[2];

    logic [15:0] m_a[2];
    logic [7:0]  m_d[2];
    logic [7:0]  m_rdata[2];
    logic [6:0]  m_r[2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    cv_bus_master #(.IO_AUTO_WAIT(AW), .WAIT_TIMEOUT(TO0)) u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .cmd_i(cmd_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_w[0]), .err_o(err_w[0]),
        .rdata_o(rdata_w[0]), .busy_o(busy_w[0]), .a_o(a_w[0]), .d_o(d_w[0]),
        .d_oe_o(oe_w[0]), .d_i(d_i), .mreq_n_o(mreq_w[0]), .iorq_n_o(iorq_w[0]),
        .rd_n_o(rd_w[0]), .wr_n_o(wr_w[0]), .rfsh_n_o(rfsh_w[0]),
        .wait_n_i(wait_n_i), .dbg_state_o(st_w[0])
    );

    cv_bus_master #(.IO_AUTO_WAIT(AW), .WAIT_TIMEOUT(TO1)) u_dut_to (
        .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .cmd_i(cmd_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_w[1]), .err_o(err_w[1]),
        .rdata_o(rdata_w[1]), .busy_o(busy_w[1]), .a_o(a_w[1]), .d_o(d_w[1]),
        .d_oe_o(oe_w[1]), .d_i(d_i), .mreq_n_o(mreq_w[1]), .iorq_n_o(iorq_w[1]),
        .rd_n_o(rd_w[1]), .wr_n_o(wr_w[1]), .rfsh_n_o(rfsh_w[1]),
        .wait_n_i(wait_n_i), .dbg_state_o(st_w[1])
    );

    function automatic obs_t get_obs(input int i);
        obs_t o;
        o.a = a_w[i];       o.d = d_w[i];       o.oe = oe_w[i];
        o.mreq = mreq_w[i]; o.iorq = iorq_w[i]; o.rd = rd_w[i];
        o.wr = wr_w[i];     o.rfsh = rfsh_w[i]; o.busy = busy_w[i];
        o.ack = ack_w[i];   o.err = err_w[i];   o.rdata = rdata_w[i];
        return o;
    endfunction

    function automatic obs_t idle_obs(input int i);
        obs_t o;
        o = '0;
        o.a = m_a[i]; o.d = m_d[i]; o.rdata = m_rdata[i];
        o.mreq = 1'b1; o.iorq = 1'b1; o.rd = 1'b1; o.wr = 1'b1; o.rfsh = 1'b1;
        return o;
    endfunction

    function automatic bit wait_low(input int k, input int ws, input int wl);
        return (k >= ws) && (k < ws + wl);
    endfunction

    // Bus-cycle schedule (cycle index k counted from the request edge).
    function automatic void model_sched(input int to, input logic [1:0] cmd,
                                        input int ws, input int wl,
                                        output int t3, output int ack_k,
                                        output bit abort);
        int k0;
        int ntw;
        k0 = 2 + (cmd[1] ? AW : 0);
        ntw = 0;
        abort = 1'b0;
        if (wait_low(k0, ws, wl)) begin
            for (int j = 1; j <= to; j++) begin
                ntw = j;
                if (!wait_low(k0 + j, ws, wl)) break;
                if (j == to) abort = 1'b1;
            end
        end
        t3 = k0 + ntw + 1;
        ack_k = t3 + ((RF && cmd == 2'b00) ? 2 : 0) + 1;
    endfunction

    function automatic obs_t model_obs(input int i, input logic [1:0] cmd,
                                       input logic [15:0] addr, input logic [7:0] wdata,
                                       input logic [7:0] din, input int k, input int t3,
                                       input int ack_k, input bit abort);
        obs_t o;
        bit is_io, is_wr, rf, bus, r1, r2;
        is_io = cmd[1];
        is_wr = cmd[0];
        rf    = RF && (cmd == 2'b00);
        bus   = (k >= 1) && (k <= t3);
        r1    = rf && (k == t3 + 1);
        r2    = rf && (k == t3 + 2);
        o.mreq  = !((bus && !is_io) || r1);
        o.iorq  = !(bus && is_io && k >= 2);
        o.rd    = !(bus && !is_wr && (!is_io || k >= 2));
        o.wr    = !(bus && is_wr && k >= 2);
        o.rfsh  = !(r1 || r2);
        o.oe    = bus && is_wr;
        o.busy  = (k < ack_k);
        o.ack   = (k == ack_k);
        o.err   = (k == ack_k) && abort;
        o.a     = (k > t3 && rf) ? {8'h00, 1'b0, m_r[i]} : addr;
        o.d     = is_wr ? wdata : m_d[i];
        o.rdata = (k > t3 && !is_wr && !abort) ? din : m_rdata[i];
        return o;
    endfunction

    task automatic commit_model(input int i, input logic [1:0] cmd, input logic [15:0] addr,
                                input logic [7:0] wdata, input logic [7:0] din, input bit abort);
        bit rf;
        rf = RF && (cmd == 2'b00);
        m_a[i] = rf ? {8'h00, 1'b0, m_r[i]} : addr;
        if (rf) m_r[i] = m_r[i] + 7'd1;
        if (cmd[0]) m_d[i] = wdata;
        if (!cmd[0] && !abort) m_rdata[i] = din;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_a[i] = '0; m_d[i] = '0; m_rdata[i] = '0; m_r[i] = '0;
        end
    endtask

    task automatic check_obs(input string name, input int i, input int k,
                             input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d k=%0d got=%h exp=%h", name, i, k, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk_i); #1;
            req_i = 1'b0;
            wait_n_i = 1'b1;
            @(negedge clk_i);
            for (int i = 0; i < 2; i++) check_obs("idle", i, c, get_obs(i), idle_obs(i));
        end
    endtask

    // Called between a negedge and the next posedge; that posedge samples req.
    task automatic run_txn(input logic [1:0] cmd, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [7:0] din,
                           input int ws, input int wl,
                           output int lat0, output int lat1,
                           output bit err0, output bit err1);
        int t3[2];
        int ack_k[2];
        bit abort[2];
        int kmax;
        obs_t got;
        model_sched(TO0, cmd, ws, wl, t3[0], ack_k[0], abort[0]);
        model_sched(TO1, cmd, ws, wl, t3[1], ack_k[1], abort[1]);
        kmax = (ack_k[0] > ack_k[1]) ? ack_k[0] : ack_k[1];
        req_i = 1'b1; cmd_i = cmd; addr_i = addr; wdata_i = wdata; d_i = din;
        wait_n_i = 1'b1;
        lat0 = -1; lat1 = -1; err0 = 1'b0; err1 = 1'b0;
        for (int k = 1; k <= kmax; k++) begin
            @(posedge clk_i); #1;
            req_i = 1'b0;
            wait_n_i = !wait_low(k, ws, wl);
            @(negedge clk_i);
            for (int i = 0; i < 2; i++) begin
                got = get_obs(i);
                check_obs("bus", i, k,
                          got, model_obs(i, cmd, addr, wdata, din, k, t3[i], ack_k[i], abort[i]));
                if (got.ack === 1'b1 && i == 0 && lat0 < 0) begin lat0 = k; err0 = got.err; end
                if (got.ack === 1'b1 && i == 1 && lat1 < 0) begin lat1 = k; err1 = got.err; end
            end
        end
        for (int i = 0; i < 2; i++) commit_model(i, cmd, addr, wdata, din, abort[i]);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   lat0, lat1;
        bit   err0, err1;
        int   rfadd;
        logic [1:0] rc;

        vecs[0] = '{2'b00, 16'h8000, 8'h00, 8'hA5, 0, 0,    4,   1'b0, 4, 1'b0};
        vecs[1] = '{2'b11, 16'h0050, 8'h07, 8'h00, 0, 0,    5,   1'b0, 5, 1'b0};
        vecs[2] = '{2'b01, 16'h6000, 8'hC3, 8'h00, 2, 4,    8,   1'b0, 7, 1'b1};
        vecs[3] = '{2'b00, 16'h4000, 8'h00, 8'h77, 2, 1000, 259, 1'b1, 7, 1'b1};
        vecs[4] = '{2'b10, 16'h1234, 8'h00, 8'h3C, 3, 1,    6,   1'b0, 6, 1'b0};
        vecs[5] = '{2'b00, 16'h0000, 8'h00, 8'hE1, 2, 1,    5,   1'b0, 5, 1'b0};
        vecs[6] = '{2'b10, 16'hFFFF, 8'h00, 8'h96, 0, 0,    5,   1'b0, 5, 1'b0};
        vecs[7] = '{2'b01, 16'h7FFF, 8'h5A, 8'h00, 0, 0,    4,   1'b0, 4, 1'b0};

        reset_i = 1'b1; req_i = 1'b0; cmd_i = 2'b00; addr_i = '0;
        wdata_i = '0; d_i = '0; wait_n_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        for (int i = 0; i < 2; i++) check_obs("reset", i, 0, get_obs(i), idle_obs(i));

        // Table rows run back to back: each request is raised in the ack cycle.
        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].cmd, vecs[v].addr, vecs[v].wdata, vecs[v].din,
                    vecs[v].ws, vecs[v].wl, lat0, lat1, err0, err1);
            rfadd = (RF && vecs[v].cmd == 2'b00) ? 2 : 0;
            check_int($sformatf("vec%0d_lat0", v), lat0, vecs[v].lat0 + rfadd);
            check_int($sformatf("vec%0d_err0", v), int'(err0), int'(vecs[v].err0));
            check_int($sformatf("vec%0d_lat1", v), lat1, vecs[v].lat1 + rfadd);
            check_int($sformatf("vec%0d_err1", v), int'(err1), int'(vecs[v].err1));
        end

        // Reset while the default instance sits in TW.
        idle_cycles(1);
        req_i = 1'b1; cmd_i = 2'b01; addr_i = 16'h6000; wdata_i = 8'h3C; wait_n_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk_i); #1;
            req_i = 1'b0;
            wait_n_i = (k < 2);
            @(negedge clk_i);
        end
        check_int("rst_pre_state_tw", int'(st_w[0]), int'(ST_TW));
        check_int("rst_pre_wr_low", int'(wr_w[0]), 0);
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        wait_n_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        for (int i = 0; i < 2; i++) check_obs("rst_idle", i, 0, get_obs(i), idle_obs(i));
        idle_cycles(3);
        run_txn(2'b00, 16'h8000, 8'h00, 8'h5A, 0, 0, lat0, lat1, err0, err1);
        check_int("post_rst_lat", lat0, 4 + (RF ? 2 : 0));
        check_int("post_rst_err", int'(err0), 0);

        // Random commands, wait patterns and inter-request gaps.
        for (int t = 0; t < 40; t++) begin
            idle_cycles($urandom_range(0, 2));
            rc = 2'($urandom_range(0, 3));
            run_txn(rc, 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), $urandom_range(2, 4), $urandom_range(0, 5),
                    lat0, lat1, err0, err1);
        end
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
